// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: takes the round-10 key and emits round keys 10..0 over valid/ready.
// Optional AES_INV_KEY_MIXCOL_EN: present InvMixColumns of keys 9..1 for the equivalent inverse cipher.
module aes_inv_key_sched #(
  parameter int word_size  = 8,
  parameter int array_size = 16,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              load,
  input  logic [word_size*array_size-1:0]   key_in,
  input  logic                              key_ready,
  output logic [word_size*array_size-1:0]   round_key,
  output logic [3:0]                        round_idx,
  output logic                              key_valid,
  output logic                              done
);

  localparam int KW = word_size * array_size;

  typedef enum logic [1:0] {IDLE, PRESENT, FINISH} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t          state, state_n;
  logic [KW-1:0]   sched, sched_n;
  logic [3:0]      idx_n;
  logic            vld_n, done_n;

  // Backward step: w[i-4] = w[i] ^ w[i-1], with the first word undoing SubWord/Rcon.
  logic [31:0] w0, w1, w2, w3, p3, rot_w, sub_w;
  logic [KW-1:0] prev_key;

  assign {w0, w1, w2, w3} = sched;
  assign p3    = w3 ^ w2;
  assign rot_w = {p3[23:0], p3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    assign sub_w[8*b +: 8] = SBOX[rot_w[8*b +: 8]];
  end

  assign prev_key = {w0 ^ sub_w ^ {rcon(round_idx), 24'h0}, w1 ^ w0, w2 ^ w1, p3};

  always_comb begin
    state_n = state;
    sched_n = sched;
    idx_n   = round_idx;
    vld_n   = key_valid;
    done_n  = done;
    if (enable) begin
      case (state)
        IDLE, FINISH: begin
          if (load) begin
            sched_n = key_in;
            idx_n   = 4'(NUM_ROUNDS);
            vld_n   = 1'b1;
            done_n  = 1'b0;
            state_n = PRESENT;
          end
        end
        PRESENT: begin
          if (key_ready) begin
            if (round_idx != 4'd0) begin
              sched_n = prev_key;
              idx_n   = round_idx - 4'd1;
            end else begin
              vld_n   = 1'b0;
              done_n  = 1'b1;
              state_n = FINISH;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sched     <= '0;
      round_idx <= 4'd0;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sched     <= sched_n;
      round_idx <= idx_n;
      key_valid <= vld_n;
      done      <= done_n;
    end
  end

`ifdef AES_INV_KEY_MIXCOL_EN
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      m9[i] = m8[i] ^ a[i];
      mb[i] = m8[i] ^ m2[i] ^ a[i];
      md[i] = m8[i] ^ m4[i] ^ a[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // First and last round keys are used raw by the equivalent inverse cipher.
  always_comb begin
    round_key = sched;
    if (round_idx != 4'd0 && round_idx != 4'(NUM_ROUNDS)) begin
      for (int c = 0; c < 4; c++) round_key[32*c +: 32] = imc_col(sched[32*c +: 32]);
    end
  end
`else
  assign round_key = sched;
`endif

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench: forward-expands a cipher key, queues keys 10..0, checks them as they are accepted.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst, enable, load, key_ready;
  logic [127:0] key_in, round_key;
  logic [3:0]   round_idx;
  logic         key_valid, done;

  aes_inv_key_sched dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .key_in(key_in),
    .key_ready(key_ready), .round_key(round_key), .round_idx(round_idx),
    .key_valid(key_valid), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] idx; logic [127:0] key;} exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from the field inverse (a^254) and the affine map.
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] exp_present(input logic [127:0] k, input int r);
    logic [127:0] o;
    o = k;
`ifdef AES_INV_KEY_MIXCOL_EN
    if (r >= 1 && r <= 9) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = k[32*c +: 32];
        o[32*c +: 32] = {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
                         gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
                         gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
                         gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
      end
    end
`endif
    return o;
  endfunction

  // Forward key expansion; queues the expected presentations in walk order.
  task automatic push_walk(input logic [127:0] ck, output logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    exp_t        e;
    {w[0], w[1], w[2], w[3]} = ck;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 10; r >= 0; r--) begin
      e.idx = 4'(r);
      e.key = exp_present({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, r);
      q.push_back(e);
    end
    k10 = {w[40], w[41], w[42], w[43]};
  endtask

  // Monitor: pops on each accepted key and checks that unaccepted keys hold still.
  logic         prev_valid = 1'b0, prev_hs = 1'b0;
  logic [127:0] prev_key = '0;
  always @(negedge clk) begin
    logic hs;
    exp_t e;
    hs = !rst && enable && key_valid && key_ready;
    if (!rst && prev_valid && !prev_hs) begin
      chk("stable_key", round_key, prev_key);
      chk("stable_vld", key_valid, 1'b1);
    end
    if (hs) begin
      hs_cnt++;
      if (q.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
      else begin
        e = q.pop_front();
        chk("sb_idx", round_idx, e.idx);
        chk("sb_key", round_key, e.key);
      end
    end
    prev_valid = key_valid && !rst;
    prev_hs    = hs;
    prev_key   = round_key;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k);
    key_in = k;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic run_done(input string tag);
    for (int i = 0; i < 60 && !done; i++) step();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_vld0"}, key_valid, 1'b0);
    chk({tag, "_hs"}, 128'(hs_cnt), 128'd11);
    chk({tag, "_qempty"}, 128'(q.size()), 128'd0);
  endtask

  localparam logic [127:0] FIPS_CK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;

  initial begin
    logic [127:0] k10, ck;
    rst = 1'b1; enable = 1'b0; load = 1'b0; key_ready = 1'b0; key_in = '0;
    step(); step();
    chk("rst_key", round_key, '0);
    chk("rst_idx", round_idx, 4'd0);
    chk("rst_vld", key_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0; enable = 1'b1;

    // Continuous acceptance with the FIPS-197 key.
    hs_cnt = 0;
    push_walk(FIPS_CK, k10);
    key_ready = 1'b1;
    do_load(FIPS_K10);
    chk("a_idx10", round_idx, 4'd10);
    chk("a_vld", key_valid, 1'b1);
    chk("a_key10", round_key, exp_present(FIPS_K10, 10));
    step();
    chk("a_idx9", round_idx, 4'd9);
    chk("a_key9", round_key, exp_present(FIPS_K9, 9));
    run_done("a");

    // Random ready with an enable gap.
    hs_cnt = 0;
    push_walk(FIPS_CK, k10);
    key_ready = 1'b0;
    do_load(k10);
    for (int i = 0; i < 200 && !done; i++) begin
      key_ready = 1'($urandom_range(0, 1));
      enable    = !(i >= 4 && i <= 6);
      step();
    end
    enable = 1'b1;
    run_done("b");

    // Load mid-walk is ignored; load from FINISH restarts.
    hs_cnt = 0;
    ck = {$urandom, $urandom, $urandom, $urandom};
    push_walk(ck, k10);
    key_ready = 1'b1;
    do_load(k10);
    for (int i = 0; i < 40 && !done; i++) begin
      load   = (round_idx == 4'd6) && key_valid;
      key_in = ~k10;
      step();
    end
    load = 1'b0;
    run_done("c");
    hs_cnt = 0;
    push_walk(ck, k10);
    key_ready = 1'b0;
    do_load(k10);
    chk("c_reload_done", done, 1'b0);
    chk("c_reload_vld", key_valid, 1'b1);
    chk("c_reload_idx", round_idx, 4'd10);
    key_ready = 1'b1;
    run_done("c2");

    // Reset mid-walk, then a fresh load.
    push_walk(FIPS_CK, k10);
    do_load(k10);
    for (int i = 0; i < 20 && round_idx != 4'd4; i++) step();
    chk("d_at4", round_idx, 4'd4);
    rst = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
    chk("d_key0", round_key, '0);
    chk("d_idx0", round_idx, 4'd0);
    chk("d_vld0", key_valid, 1'b0);
    chk("d_done0", done, 1'b0);
    step();
    chk("d_idle", key_valid, 1'b0);
    hs_cnt = 0;
    push_walk(FIPS_CK, k10);
    do_load(k10);
    chk("d_idx10", round_idx, 4'd10);
    run_done("d");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Reverse-order AES-128 round-key generator for the decryption datapath.
- Accepts the final (round-10) round key and walks the key schedule backwards, producing round keys 10, 9, …, 0 one at a time.
- Each key is offered to the inverse-cipher round logic over a valid/ready handshake. Shares the codebase's 128-bit byte-array bus convention and clk/rst/enable/load/done control style.

Parameters:
- word_size, 8, bits per byte lane; only 8 supported.
- array_size, 16, bytes per block; only 16 supported.
- NUM_ROUNDS, 10, AES-128 round count; fixed, drives round counter width (4 bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  clock enable; when 0 all registers hold and no handshake completes.
- load  input  1  start pulse; samples key_in when accepted.
- key_in  input  128  round-10 key; FIPS-197 byte 0 at [127:120], word w0 = [127:96].
- key_ready  input  1  consumer accepts round_key this cycle.
- round_key  output  128  current round key, same byte order as key_in.
- round_idx  output  4  round number of round_key (10 down to 0).
- key_valid  output  1  round_key/round_idx valid.
- done  output  1  high once round 0 is accepted; held until next load or rst.

Behaviour:
- Reset (rst=1 at clk edge, takes priority over everything, including enable=0): state=IDLE; round_key=0, round_idx=0, key_valid=0, done=0. Aborts any walk in progress.
- States: IDLE, PRESENT, FINISH.
- IDLE: on enable & load, register key_in into round_key, round_idx=10, key_valid=1 → PRESENT. Latency: load edge → key_valid high the next cycle.
- PRESENT: key_valid=1. Handshake completes on a cycle with enable & key_valid & key_ready.
  - If round_idx>0: next cycle round_key = previous key, round_idx decrements, key_valid stays 1. This gives one key per cycle under continuous key_ready.
  - If round_idx=0: key_valid=0, done=1 → FINISH.
- Previous-key computation, with w0..w3 the current words and Rcon indexed by current round_idx r (01,02,04,08,10,20,40,80,1b,36 for r=1..10):
  - p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],00,00,00}.
  - RotWord = cyclic left shift by one byte.
  - SubWord = forward AES S-box per byte, combinational.
- FINISH: done=1, key_valid=0. load with enable → same as IDLE load and clears done the cycle the first key is presented.
- load while in PRESENT is ignored; the walk continues.
- key_ready while key_valid=0 has no effect.
- enable=0 mid-walk freezes round_key, round_idx, key_valid and done; outputs stay stable and the handshake is not counted.
- round_key never changes while key_valid=1 and no handshake has completed.

Optional Feature:
- Macro: AES_INV_KEY_MIXCOL_EN.
- Defined: for round_idx 9..1, round_key presents InvMixColumns(schedule key) applied per 32-bit column, for the equivalent inverse cipher. Rounds 10 and 0 are presented unmodified. The internal schedule register always holds the raw key, so the backward walk is unaffected.
- Undefined: round_key is always the raw schedule key; no InvMixColumns logic is synthesized.

Test Plan:
- Reset, then load key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 with key_ready=1 → next cycle round_idx=10 and round_key=d014f9a8…0ca6. Following cycle round_idx=9, round_key=ac7766f319fadc2128d12941575c006e.
- Same load, key_ready held 1 → 11 consecutive valid cycles. round_idx=1 gives a0fafe1788542cb123a339392a6c7605. round_idx=0 gives 2b7e151628aed2a6abf7158809cf4f3c. done=1 the cycle after round 0 is accepted, with key_valid=0.
- Toggle key_ready pseudo-randomly and drop enable for 3 cycles mid-walk → round_key stable while unaccepted; the sequence matches the previous test exactly; exactly 11 handshakes.
- Assert load at round_idx=6 → ignored; walk completes normally. Then load from FINISH → done clears and round 10 is re-presented.
- Assert rst at round_idx=4 → next cycle all outputs 0, state IDLE. A fresh load restarts at round 10.
- With AES_INV_KEY_MIXCOL_EN defined → rounds 10 and 0 equal the raw keys above. Rounds 9..1 match the model's InvMixColumns of the raw keys, e.g. round 9 = InvMixColumns(ac7766f3…006e).
